muldiv_seq_ctrl: RTL and testbench

MULDIV_SEQ_CTRL -- requirements
Module: muldiv_seq_ctrl

---
 rtl/muldiv_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_muldiv_seq_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl: sequencing controller between the execute stage and an
// external multi-cycle multiplier. Latches the op on accept, waits LATENCY
// cycles for the product, then holds the writeback result until it is taken.
// Optional feature: define MULDIV_SEQ_FUSE_EN to add a one-entry product cache
// that lets a repeated operand pair (same product class) complete in one cycle.
module muldiv_seq_ctrl #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_opcode,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  input  logic [4:0]  req_tag,
  input  logic        flush,
  output logic [1:0]  mul_opcode,
  output logic [31:0] mul_op1,
  output logic [31:0] mul_op2,
  input  logic [63:0] mul_product,
  output logic        resp_valid,
  output logic [31:0] resp_result,
  output logic [4:0]  resp_tag,
  input  logic        resp_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] CNT_LOAD = 2'(LATENCY - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cnt;
  logic       accept;
  logic       capture;
  logic       hit;

  // MUL returns the low word; all high-half variants return the upper word.
  function automatic logic [31:0] sel_half(input logic [1:0] op, input logic [63:0] p);
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

`ifdef MULDIV_SEQ_FUSE_EN
  // MUL and MULH share a signed x signed product, so they form one class.
  function automatic logic [1:0] op_class(input logic [1:0] op);
    return {op[1], op[1] & op[0]};
  endfunction

  logic        cache_vld;
  logic [63:0] cache_prod;
  logic [31:0] cache_op1;
  logic [31:0] cache_op2;
  logic [1:0]  cache_cls;

  assign hit = cache_vld && (cache_op1 == req_op1) && (cache_op2 == req_op2) &&
               (cache_cls == op_class(req_opcode));

  // Product cache: refilled on every multiplier capture, invalidated on kill.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cache_vld <= 1'b0;
    end else if (capture) begin
      cache_vld  <= 1'b1;
      cache_prod <= mul_product;
      cache_op1  <= mul_op1;
      cache_op2  <= mul_op2;
      cache_cls  <= op_class(mul_opcode);
    end
  end
`else
  assign hit = 1'b0;
`endif

  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, handshake and capture strobes; flush overrides everything.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      CALC:    capture   = (cnt == 2'd0);
      DONE:    req_ready = resp_ready;
      default: req_ready = 1'b0;
    endcase
    accept = req_valid && req_ready && !flush;
    case (state)
      IDLE: begin
        if (accept) state_nxt = hit ? DONE : CALC;
      end
      CALC: begin
        if (capture) state_nxt = DONE;
      end
      DONE: begin
        if (accept)          state_nxt = hit ? DONE : CALC;
        else if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      capture   = 1'b0;
    end
  end

  // Operand latch, latency counter and result/tag holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 2'd0;
      mul_opcode  <= 2'b00;
      mul_op1     <= 32'd0;
      mul_op2     <= 32'd0;
      resp_result <= 32'd0;
      resp_tag    <= 5'd0;
    end else begin
      if (accept) begin
        mul_opcode <= req_opcode;
        mul_op1    <= req_op1;
        mul_op2    <= req_op2;
        resp_tag   <= req_tag;
        cnt        <= CNT_LOAD;
      end else if (state == CALC && cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end
      if (capture) begin
        resp_result <= sel_half(mul_opcode, mul_product);
      end
`ifdef MULDIV_SEQ_FUSE_EN
      if (accept && hit) begin
        resp_result <= sel_half(req_opcode, cache_prod);
      end
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// tb_muldiv_seq_ctrl: directed vectors with a response scoreboard; the bench
// also models the external multiplier from the DUT's registered operands.
module tb_muldiv_seq_ctrl;
  localparam int LAT = 2;
`ifdef MULDIV_SEQ_FUSE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = LAT;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_opcode;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [4:0]  req_tag;
  logic        flush;
  logic [1:0]  mul_opcode;
  logic [31:0] mul_op1;
  logic [31:0] mul_op2;
  logic [63:0] mul_product;
  logic        resp_valid;
  logic [31:0] resp_result;
  logic [4:0]  resp_tag;
  logic        resp_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int a1, a2;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          due;
    bit          seen;
  } exp_t;
  exp_t q[$];

  muldiv_seq_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
    .flush(flush),
    .mul_opcode(mul_opcode), .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_product(mul_product),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_tag(resp_tag),
    .resp_ready(resp_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: sign-extend per opcode, keep 64 bits of the product.
  always_comb begin
    logic [63:0] a;
    logic [63:0] b;
    a = {32'd0, mul_op1};
    b = {32'd0, mul_op2};
    if (mul_opcode != 2'b11) a = {{32{mul_op1[31]}}, mul_op1};
    if (mul_opcode[1] == 1'b0) b = {{32{mul_op2[31]}}, mul_op2};
    mul_product = a * b;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] res, input int lat,
                       output int acc);
    exp_t e;
    req_valid  = 1'b1;
    req_opcode = op;
    req_op1    = a;
    req_op2    = b;
    req_tag    = tag;
    acc        = -1;
    for (int i = 0; i < 30; i++) begin
      if (req_ready) begin
        acc    = cyc + 1;
        e.res  = res;
        e.tag  = tag;
        e.due  = acc + lat;
        e.seen = 1'b0;
        q.push_back(e);
        tick();
        break;
      end
      tick();
    end
    req_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", req_ready, 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("resp_valid_seen", resp_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("queue_drained", q.size(), 0);
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_resp", resp_valid, 0);
      end else begin
        if (!q[0].seen) begin
          chk("resp_latency", cyc, q[0].due);
          q[0].seen = 1'b1;
        end
        chk("resp_result", resp_result, q[0].res);
        chk("resp_tag", resp_tag, q[0].tag);
        if (resp_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_opcode = 2'b00;
    req_op1 = 32'd0; req_op2 = 32'd0; req_tag = 5'd0; resp_ready = 1'b1;
    tick();
    tick();
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_resp_tag", resp_tag, 0);
    chk("rst_mul_opcode", mul_opcode, 0);
    chk("rst_mul_op1", mul_op1, 0);
    chk("rst_mul_op2", mul_op2, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    rst = 1'b0;
    tick();

    // MULHU all-ones squared: high word 0xFFFFFFFE.
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, LAT, a1);
    chk("calc_req_ready", req_ready, 0);
    chk("calc_busy", busy, 1);
    drain();

    // MUL then MULH of 0x80000000 squared, second accepted in the DONE cycle.
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h0000_0000, LAT, a1);
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, HIT_LAT, a2);
    chk("b2b_accept_gap", a2 - a1, LAT + 1);
    drain();

    // MULHSU -1 x 2 with writeback stalled for three cycles.
    resp_ready = 1'b0;
    issue(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 5'd9, 32'hFFFF_FFFF, LAT, a1);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      chk("stall_req_ready", req_ready, 0);
      chk("stall_resp_valid", resp_valid, 1);
      tick();
    end
    resp_ready = 1'b1;
    drain();

    // Flush in CALC cycle 1 while a new request is offered.
    issue(2'b00, 32'd5, 32'd6, 5'd7, 32'd30, LAT, a1);
    flush = 1'b1; req_valid = 1'b1; req_opcode = 2'b11;
    req_op1 = 32'd9; req_op2 = 32'd9; req_tag = 5'd12;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    q.delete();
    chk("flush_busy", busy, 0);
    chk("flush_resp_valid", resp_valid, 0);
    chk("flush_req_ready", req_ready, 1);
    chk("flush_mul_op1", mul_op1, 5);
    chk("flush_mul_opcode", mul_opcode, 0);
    // Flush in IDLE must also block an offered request.
    flush = 1'b1; req_valid = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_idle_busy", busy, 0);
    chk("flush_idle_mul_op1", mul_op1, 5);
    repeat (5) tick();

    // Reset while a response is held in DONE, then the same op again.
    resp_ready = 1'b0;
    issue(2'b00, 32'd3, 32'd7, 5'd10, 32'd21, LAT, a1);
    wait_valid();
    tick();
    rst = 1'b1;
    tick();
    q.delete();
    chk("rst2_resp_valid", resp_valid, 0);
    chk("rst2_resp_result", resp_result, 0);
    chk("rst2_resp_tag", resp_tag, 0);
    chk("rst2_mul_opcode", mul_opcode, 0);
    chk("rst2_mul_op1", mul_op1, 0);
    chk("rst2_mul_op2", mul_op2, 0);
    chk("rst2_busy", busy, 0);
    rst = 1'b0;
    resp_ready = 1'b1;
    tick();
    issue(2'b00, 32'd3, 32'd7, 5'd11, 32'd21, LAT, a1);
    drain();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
